// File: rtl/mult_div_unit_if.sv
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request/result bundle between the MIPS control unit and the
//                multicycle multiply/divide sequencer.
//                  start, op, a_in, b_in       : request (control -> unit)
//                  busy, done, hi_out, lo_out,
//                  div_zero                    : status/results (unit -> control)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_zero;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, hi_out, lo_out, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multicycle signed multiply/divide sequencer for mult/div.
//                Runs WIDTH shift-add (multiply) or restoring (divide) steps
//                on operand magnitudes, then one sign-fix cycle that writes
//                HI/LO and pulses done.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-high reset
//                bus    - mult_div_unit_if.slave (start/op/a_in/b_in in;
//                         busy/done/hi_out/lo_out/div_zero out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mult_div_unit_if.slave    bus
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic               r_op, w_op;
    logic               r_sign_a, w_sign_a;
    logic               r_sign_b, w_sign_b;
    logic               r_dz, w_dz;
    logic [WIDTH-1:0]   r_mag_b, w_mag_b;
    // Multiply: {P_hi, P_lo} with bit WIDTH of r_acc_hi unused (kept 0).
    // Divide:   R (WIDTH+1 bits) in r_acc_hi, Q in r_acc_lo.
    logic [WIDTH:0]     r_acc_hi, w_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo, w_acc_lo;
    logic [c_CNT_W-1:0] r_cnt, w_cnt;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_div_zero, w_div_zero;
    logic [WIDTH-1:0]   r_hi, w_hi;
    logic [WIDTH-1:0]   r_lo, w_lo;

    // Operand magnitudes; 0x80..0 maps to itself and is read as unsigned.
    logic [WIDTH-1:0]   w_mag_a_in;
    logic [WIDTH-1:0]   w_mag_b_in;
    assign w_mag_a_in = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    assign w_mag_b_in = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

    // Multiply step datapath: conditional add with carry out.
    logic [WIDTH:0]     w_sum;
    assign w_sum = {1'b0, r_acc_hi[WIDTH-1:0]} + {1'b0, r_mag_b};

    // Divide step datapath: R shifted left with Q's MSB, then trial subtract.
    // The shifted R can exceed 2^WIDTH, so compare rather than test a sign bit.
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    assign w_rsh   = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    assign w_trial = w_rsh - {1'b0, r_mag_b};
    assign w_ge    = (w_rsh >= {1'b0, r_mag_b});

    // Sign-correction datapath used in FIX.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    assign w_prod     = {r_acc_hi[WIDTH-1:0], r_acc_lo};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_q_fix    = (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
    assign w_r_fix    = r_sign_a ? -r_acc_hi[WIDTH-1:0] : r_acc_hi[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dz       <= 1'b0;
            r_mag_b    <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state    <= w_state;
            r_op       <= w_op;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_dz       <= w_dz;
            r_mag_b    <= w_mag_b;
            r_acc_hi   <= w_acc_hi;
            r_acc_lo   <= w_acc_lo;
            r_cnt      <= w_cnt;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_div_zero <= w_div_zero;
            r_hi       <= w_hi;
            r_lo       <= w_lo;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_op       = r_op;
        w_sign_a   = r_sign_a;
        w_sign_b   = r_sign_b;
        w_dz       = r_dz;
        w_mag_b    = r_mag_b;
        w_acc_hi   = r_acc_hi;
        w_acc_lo   = r_acc_lo;
        w_cnt      = r_cnt;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_div_zero = r_div_zero;
        w_hi       = r_hi;
        w_lo       = r_lo;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_op       = bus.op;
                    w_sign_a   = bus.a_in[WIDTH-1];
                    w_sign_b   = bus.b_in[WIDTH-1];
                    w_mag_b    = w_mag_b_in;
                    w_acc_hi   = '0;
                    w_acc_lo   = w_mag_a_in;
                    w_cnt      = '0;
                    w_div_zero = 1'b0;
                    w_busy     = 1'b1;
                    if (bus.op && (bus.b_in == '0)) begin
                        // Skip iterations entirely; FIX only raises the flag.
                        w_dz    = 1'b1;
                        w_state = S_FIX;
                    end else begin
                        w_dz    = 1'b0;
                        w_state = bus.op ? S_DIV : S_MULT;
                    end
                end
            end

            S_MULT: begin
                if (r_acc_lo[0]) begin
                    w_acc_hi = {1'b0, w_sum[WIDTH:1]};
                    w_acc_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
                end else begin
                    w_acc_hi = {2'b00, r_acc_hi[WIDTH-1:1]};
                    w_acc_lo = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
                end
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state = S_FIX;
                end
            end

            S_DIV: begin
                w_acc_lo = {r_acc_lo[WIDTH-2:0], w_ge};
                w_acc_hi = w_ge ? w_trial : w_rsh;
                w_cnt    = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state = S_FIX;
                end
            end

            S_FIX: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
                if (r_dz) begin
                    w_div_zero = 1'b1;
                end else if (r_op) begin
                    w_lo = w_q_fix;
                    w_hi = w_r_fix;
                end else begin
                    w_hi = w_prod_fix[2*WIDTH-1:WIDTH];
                    w_lo = w_prod_fix[WIDTH-1:0];
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.hi_out   = r_hi;
    assign bus.lo_out   = r_lo;
    assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Directed self-checking bench for mult_div_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    int   edges;
    int   busy_gaps;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request so it is sampled on the next rising edge (edge E);
    // returns #1 after E with start already dropped.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done is seen (-1 if it never comes), noting any
    // cycle before done in which busy was low.
    task automatic wait_done(output int n, output int gaps);
        n    = -1;
        gaps = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                n = k;
                break;
            end
            if (bus.busy !== 1'b1) gaps++;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        #2;
        chk("rst_hi",   64'(bus.hi_out),   64'h0);
        chk("rst_lo",   64'(bus.lo_out),   64'h0);
        chk("rst_busy", 64'(bus.busy),     64'h0);
        chk("rst_done", 64'(bus.done),     64'h0);
        chk("rst_dz",   64'(bus.div_zero), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // 7 * -3
        launch(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
        chk("mul1_busy", 64'(bus.busy), 64'h1);
        wait_done(edges, busy_gaps);
        chk("mul1_lat",  64'(edges), 64'd33);
        chk("mul1_gaps", 64'(busy_gaps), 64'd0);
        chk("mul1_hi",   64'(bus.hi_out), 64'hFFFF_FFFF);
        chk("mul1_lo",   64'(bus.lo_out), 64'hFFFF_FFEB);
        chk("mul1_busy_done", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;
        chk("mul1_done_pulse", 64'(bus.done), 64'h0);
        chk("mul1_hold_lo", 64'(bus.lo_out), 64'hFFFF_FFEB);

        // 7 / -2
        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(edges, busy_gaps);
        chk("div1_lat", 64'(edges), 64'd33);
        chk("div1_lo",  64'(bus.lo_out), 64'hFFFF_FFFD);
        chk("div1_hi",  64'(bus.hi_out), 64'h0000_0001);

        // -7 / 2
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, busy_gaps);
        chk("div2_lo", 64'(bus.lo_out), 64'hFFFF_FFFD);
        chk("div2_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);

        // 100 / 7
        launch(1'b1, 32'd100, 32'd7);
        wait_done(edges, busy_gaps);
        chk("div3_lo", 64'(bus.lo_out), 64'd14);
        chk("div3_hi", 64'(bus.hi_out), 64'd2);

        // 0x80000000 * 0x80000000
        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges, busy_gaps);
        chk("mulmin_hi", 64'(bus.hi_out), 64'h4000_0000);
        chk("mulmin_lo", 64'(bus.lo_out), 64'h0);

        // 0x80000000 / -1 wraps
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, busy_gaps);
        chk("divmin_lo", 64'(bus.lo_out), 64'h8000_0000);
        chk("divmin_hi", 64'(bus.hi_out), 64'h0);
        chk("divmin_dz", 64'(bus.div_zero), 64'h0);

        // Preload HI=0x12, LO=0x34 (1006 = 52*19 + 18), then divide by zero
        launch(1'b1, 32'd1006, 32'd19);
        wait_done(edges, busy_gaps);
        chk("pre_hi", 64'(bus.hi_out), 64'h12);
        chk("pre_lo", 64'(bus.lo_out), 64'h34);
        launch(1'b1, 32'd5, 32'd0);
        chk("dz_busy", 64'(bus.busy), 64'h1);
        wait_done(edges, busy_gaps);
        chk("dz_lat",  64'(edges), 64'd1);
        chk("dz_flag", 64'(bus.div_zero), 64'h1);
        chk("dz_hi",   64'(bus.hi_out), 64'h12);
        chk("dz_lo",   64'(bus.lo_out), 64'h34);
        chk("dz_busy_done", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;
        chk("dz_flag_held", 64'(bus.div_zero), 64'h1);

        // Next accepted start clears the flag; a start mid-run is ignored.
        launch(1'b0, 32'h0000_1234, 32'h0000_0010);
        chk("dz_clear", 64'(bus.div_zero), 64'h0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd99;
        bus.b_in  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(edges, busy_gaps);
        chk("ign_lat", 64'(edges + 10), 64'd33);
        chk("ign_hi",  64'(bus.hi_out), 64'h0);
        chk("ign_lo",  64'(bus.lo_out), 64'h0001_2340);

        // Start during the done cycle: 5 * -6
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd5;
        bus.b_in  = 32'hFFFF_FFFA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'h1);
        wait_done(edges, busy_gaps);
        chk("b2b_lat", 64'(edges), 64'd33);
        chk("b2b_hi",  64'(bus.hi_out), 64'hFFFF_FFFF);
        chk("b2b_lo",  64'(bus.lo_out), 64'hFFFF_FFE2);

        // Asynchronous reset at iteration 20
        launch(1'b0, 32'h0000_1234, 32'h0000_1000);
        repeat (19) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_hi",   64'(bus.hi_out),   64'h0);
        chk("arst_lo",   64'(bus.lo_out),   64'h0);
        chk("arst_busy", 64'(bus.busy),     64'h0);
        chk("arst_done", 64'(bus.done),     64'h0);
        chk("arst_dz",   64'(bus.div_zero), 64'h0);
        @(negedge clk) reset = 1'b0;

        // Fresh 5 * 6 after reset
        launch(1'b0, 32'd5, 32'd6);
        wait_done(edges, busy_gaps);
        chk("post_lat", 64'(edges), 64'd33);
        chk("post_hi",  64'(bus.hi_out), 64'h0);
        chk("post_lo",  64'(bus.lo_out), 64'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
